// File: rtl/spi_fifo_pkg.sv
// Shared types and defaults for the SPI FIFO bridge.
//   TX FSM states : TX_IDLE, TX_SETTLE
//   RX FSM states : RX_IDLE, RX_ACK
//   DEFAULT_DEPTH : default entries per FIFO
package spi_fifo_pkg;

   localparam int unsigned DEFAULT_DEPTH = 16;

   typedef enum logic {
      TX_IDLE,
      TX_SETTLE
   } txState_t;

   typedef enum logic {
      RX_IDLE,
      RX_ACK
   } rxState_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO with an explicit occupancy counter.
//   clk, reset : clock, synchronous active-high reset
//   push       : write wrData (ignored while full)
//   pop        : advance the head (ignored while empty)
//   rdData     : current head, 0 while empty
//   count      : occupancy, full/empty decoded from it
module spi_sync_fifo
   import spi_fifo_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned CNTW      = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATAWIDTH-1:0] wrData,
   output logic [DATAWIDTH-1:0] rdData,
   output logic [CNTW-1:0]      count,
   output logic                 full,
   output logic                 empty
);

   localparam int unsigned ADDRW = $clog2(DEPTH);

   logic [DATAWIDTH-1:0] mem [DEPTH];
   logic [ADDRW-1:0]     wrPtr;
   logic [ADDRW-1:0]     rdPtr;
   logic                 pushOk;
   logic                 popOk;

   assign full   = (count == CNTW'(DEPTH));
   assign empty  = (count == '0);
   // A push is judged against the pre-edge count, so a same-cycle pop never admits it.
   assign pushOk = push && !full;
   assign popOk  = pop && !empty;
   assign rdData = empty ? '0 : mem[rdPtr];

   // Pointers wrap naturally; occupancy tracked separately.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + ADDRW'(1);
         if (popOk)  rdPtr <= rdPtr + ADDRW'(1);
         case ({pushOk, popOk})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array, no reset needed since reads are masked while empty.
   always_ff @(posedge clk) begin
      if (pushOk) mem[wrPtr] <= wrData;
   end

endmodule

// File: rtl/spi_fifo_bridge.sv
// TX/RX buffering between master-side registers and the SPI core.
//   txWrEn/txWrData         : push into TX FIFO
//   rxRdEn/rxRdData         : pop / show-ahead head of RX FIFO
//   txCount/rxCount         : occupancies; txFull, rxEmpty decoded
//   txThreshold/rxThreshold : interrupt levels for txIrq/rxIrq
//   txOverflow/rxOverflow   : sticky drop flags, cleared by flagClear
//   coreTransmit*           : load port toward the core
//   coreReceive*            : receive handshake with the core
module spi_fifo_bridge
   import spi_fifo_pkg::*;
#(
   parameter int unsigned DATAWIDTH = 8,
   parameter int unsigned DEPTH     = DEFAULT_DEPTH,
   parameter int unsigned CNTW      = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 txWrEn,
   input  logic [DATAWIDTH-1:0] txWrData,
   input  logic                 rxRdEn,
   output logic [DATAWIDTH-1:0] rxRdData,
   output logic [CNTW-1:0]      txCount,
   output logic [CNTW-1:0]      rxCount,
   output logic                 txFull,
   output logic                 rxEmpty,
   input  logic [CNTW-1:0]      txThreshold,
   input  logic [CNTW-1:0]      rxThreshold,
   output logic                 txOverflow,
   output logic                 rxOverflow,
   input  logic                 flagClear,
   output logic                 txIrq,
   output logic                 rxIrq,
   output logic [DATAWIDTH-1:0] coreTransmitData,
   output logic                 coreTransmitLoadEn,
   input  logic                 coreTransmitReady,
   input  logic [DATAWIDTH-1:0] coreReceiveData,
   input  logic                 coreReceiveValid,
   output logic                 coreReceiveReadReq
);

   txState_t             txState, txStateNext;
   rxState_t             rxState, rxStateNext;
   logic                 txPop, txEmpty, txOvfSet;
   logic                 rxCapture, rxPush, rxFull, rxOvfSet;
   logic [DATAWIDTH-1:0] txHead;

   spi_sync_fifo #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) txFifo (
      .clk    (clk),
      .reset  (reset),
      .push   (txWrEn),
      .pop    (txPop),
      .wrData (txWrData),
      .rdData (txHead),
      .count  (txCount),
      .full   (txFull),
      .empty  (txEmpty)
   );

   spi_sync_fifo #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) rxFifo (
      .clk    (clk),
      .reset  (reset),
      .push   (rxPush),
      .pop    (rxRdEn),
      .wrData (coreReceiveData),
      .rdData (rxRdData),
      .count  (rxCount),
      .full   (rxFull),
      .empty  (rxEmpty)
   );

   assign txOvfSet = txWrEn && txFull;
   assign txIrq    = (txCount <= txThreshold);
   // Count of zero never raises rxIrq, so a zero threshold acts as one.
   assign rxIrq    = (rxCount >= rxThreshold) && (rxCount != '0);

   // TX: settle cycle covers the core's registered ready dropping after a load.
   always_comb begin
      txStateNext = txState;
      txPop       = 1'b0;
      case (txState)
         TX_IDLE: begin
            if (coreTransmitReady && !txEmpty) begin
               txPop       = 1'b1;
               txStateNext = TX_SETTLE;
            end
         end
         TX_SETTLE: txStateNext = TX_IDLE;
         default:   txStateNext = TX_IDLE;
      endcase
   end

   // RX: acknowledge every valid byte, then skip one cycle while valid clears.
   always_comb begin
      rxStateNext = rxState;
      rxCapture   = 1'b0;
      case (rxState)
         RX_IDLE: begin
            if (coreReceiveValid) begin
               rxCapture   = 1'b1;
               rxStateNext = RX_ACK;
            end
         end
         RX_ACK:  rxStateNext = RX_IDLE;
         default: rxStateNext = RX_IDLE;
      endcase
   end

   assign rxPush   = rxCapture && !rxFull;
   assign rxOvfSet = rxCapture && rxFull;

   // State, strobes, load data and sticky flags (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         txState            <= TX_IDLE;
         rxState            <= RX_IDLE;
         coreTransmitLoadEn <= 1'b0;
         coreTransmitData   <= '0;
         coreReceiveReadReq <= 1'b0;
         txOverflow         <= 1'b0;
         rxOverflow         <= 1'b0;
      end else begin
         txState            <= txStateNext;
         rxState            <= rxStateNext;
         coreTransmitLoadEn <= txPop;
         if (txPop) coreTransmitData <= txHead;
         coreReceiveReadReq <= rxCapture;
         txOverflow         <= (txOverflow && !flagClear) || txOvfSet;
         rxOverflow         <= (rxOverflow && !flagClear) || rxOvfSet;
      end
   end

endmodule

// File: tb/tb_spi_fifo_bridge.sv
// Directed self-checking bench for spi_fifo_bridge (DATAWIDTH 8, DEPTH 16).
module tb_spi_fifo_bridge;

   logic       clk = 1'b0;
   logic       reset;
   logic       txWrEn;
   logic [7:0] txWrData;
   logic       rxRdEn;
   logic [7:0] rxRdData;
   logic [4:0] txCount, rxCount;
   logic       txFull, rxEmpty;
   logic [4:0] txThreshold, rxThreshold;
   logic       txOverflow, rxOverflow;
   logic       flagClear;
   logic       txIrq, rxIrq;
   logic [7:0] coreTransmitData;
   logic       coreTransmitLoadEn;
   logic       coreTransmitReady;
   logic [7:0] coreReceiveData;
   logic       coreReceiveValid;
   logic       coreReceiveReadReq;

   int checks = 0;
   int errors = 0;

   spi_fifo_bridge dut (
      .clk                (clk),
      .reset              (reset),
      .txWrEn             (txWrEn),
      .txWrData           (txWrData),
      .rxRdEn             (rxRdEn),
      .rxRdData           (rxRdData),
      .txCount            (txCount),
      .rxCount            (rxCount),
      .txFull             (txFull),
      .rxEmpty            (rxEmpty),
      .txThreshold        (txThreshold),
      .rxThreshold        (rxThreshold),
      .txOverflow         (txOverflow),
      .rxOverflow         (rxOverflow),
      .flagClear          (flagClear),
      .txIrq              (txIrq),
      .rxIrq              (rxIrq),
      .coreTransmitData   (coreTransmitData),
      .coreTransmitLoadEn (coreTransmitLoadEn),
      .coreTransmitReady  (coreTransmitReady),
      .coreReceiveData    (coreReceiveData),
      .coreReceiveValid   (coreReceiveValid),
      .coreReceiveReadReq (coreReceiveReadReq)
   );

   always #5 clk = ~clk;

   // Mid-cycle log of loads handed to the core and read-request pulses.
   logic [7:0] loadLog[$];
   int         reqPulses = 0;
   always @(negedge clk) begin
      if (coreTransmitLoadEn) loadLog.push_back(coreTransmitData);
      if (coreReceiveReadReq) reqPulses++;
   end

   typedef struct {
      logic       wr;
      logic [7:0] data;
      logic [4:0] expCount;
      logic       expLoad;
      logic [7:0] expData;
      logic       expIrq;
   } txVec_t;

   txVec_t txVecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushTx(input logic [7:0] d);
      txWrEn   = 1'b1;
      txWrData = d;
      step();
      txWrEn   = 1'b0;
   endtask

   task automatic waitTxEmpty(input string name);
      int n = 0;
      while (txCount != 5'd0 && n < 80) begin
         step();
         n++;
      end
      chk(name, 32'(txCount), 32'd0);
      repeat (3) step();
   endtask

   // Core model: hold valid until one cycle after the read request is seen.
   task automatic coreSend(input logic [7:0] d, output bit sawReq);
      coreReceiveData  = d;
      coreReceiveValid = 1'b1;
      sawReq = 1'b0;
      for (int i = 0; i < 8 && !sawReq; i++) begin
         step();
         if (coreReceiveReadReq) sawReq = 1'b1;
      end
      step();
      coreReceiveValid = 1'b0;
   endtask

   task automatic popRx(input string name, input logic [7:0] exp);
      chk(name, 32'(rxRdData), 32'(exp));
      rxRdEn = 1'b1;
      step();
      rxRdEn = 1'b0;
   endtask

   initial begin
      int  base;
      int  reqBase;
      bit  saw;

      reset = 1'b1; txWrEn = 1'b0; txWrData = '0; rxRdEn = 1'b0;
      txThreshold = 5'd0; rxThreshold = 5'd1; flagClear = 1'b0;
      coreTransmitReady = 1'b0; coreReceiveData = '0; coreReceiveValid = 1'b0;

      // Reset state
      step(); step();
      chk("rst txCount", 32'(txCount), 0);
      chk("rst rxCount", 32'(rxCount), 0);
      chk("rst txFull", 32'(txFull), 0);
      chk("rst rxEmpty", 32'(rxEmpty), 1);
      chk("rst flags", 32'({txOverflow, rxOverflow}), 0);
      chk("rst strobes", 32'({coreTransmitLoadEn, coreReceiveReadReq}), 0);
      chk("rst rxRdData", 32'(rxRdData), 0);
      chk("rst coreTransmitData", 32'(coreTransmitData), 0);

      // Test 1: three pushes with ready held, loads two cycles apart
      txVecs[0] = '{1'b1, 8'hA5, 5'd1, 1'b0, 8'h00, 1'b0};
      txVecs[1] = '{1'b1, 8'h3C, 5'd1, 1'b1, 8'hA5, 1'b0};
      txVecs[2] = '{1'b1, 8'hFF, 5'd2, 1'b0, 8'hA5, 1'b0};
      txVecs[3] = '{1'b0, 8'h00, 5'd1, 1'b1, 8'h3C, 1'b0};
      txVecs[4] = '{1'b0, 8'h00, 5'd1, 1'b0, 8'h3C, 1'b0};
      txVecs[5] = '{1'b0, 8'h00, 5'd0, 1'b1, 8'hFF, 1'b1};
      txVecs[6] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'hFF, 1'b1};
      txVecs[7] = '{1'b0, 8'h00, 5'd0, 1'b0, 8'hFF, 1'b1};
      reset = 1'b0;
      coreTransmitReady = 1'b1;
      txThreshold = 5'd0;
      for (int i = 0; i < 8; i++) begin
         txWrEn   = txVecs[i].wr;
         txWrData = txVecs[i].data;
         step();
         chk($sformatf("t1[%0d] txCount", i), 32'(txCount), 32'(txVecs[i].expCount));
         chk($sformatf("t1[%0d] loadEn", i), 32'(coreTransmitLoadEn), 32'(txVecs[i].expLoad));
         chk($sformatf("t1[%0d] txData", i), 32'(coreTransmitData), 32'(txVecs[i].expData));
         chk($sformatf("t1[%0d] txIrq", i), 32'(txIrq), 32'(txVecs[i].expIrq));
      end
      txWrEn = 1'b0;
      coreTransmitReady = 1'b0;
      step();

      // Test 5 (TX): push and internal pop in the same cycle at count 3
      base = loadLog.size();
      pushTx(8'h11); pushTx(8'h22); pushTx(8'h33);
      chk("t5 txCount pre", 32'(txCount), 3);
      txWrEn = 1'b1; txWrData = 8'h44; coreTransmitReady = 1'b1;
      step();
      txWrEn = 1'b0;
      chk("t5 txCount same", 32'(txCount), 3);
      chk("t5 loadEn", 32'(coreTransmitLoadEn), 1);
      chk("t5 loadData", 32'(coreTransmitData), 32'h11);
      waitTxEmpty("t5 drain");
      chk("t5 loads", 32'(loadLog.size() - base), 4);
      chk("t5 order0", 32'(loadLog[base]), 32'h11);
      chk("t5 order1", 32'(loadLog[base+1]), 32'h22);
      chk("t5 order2", 32'(loadLog[base+2]), 32'h33);
      chk("t5 order3", 32'(loadLog[base+3]), 32'h44);
      coreTransmitReady = 1'b0;

      // Test 2: fill TX past full with ready low, set beats clear, then drain
      base = loadLog.size();
      txThreshold = 5'd15;
      for (int i = 0; i < 16; i++) pushTx(8'h80 + 8'(i));
      chk("t2 txCount", 32'(txCount), 16);
      chk("t2 txFull", 32'(txFull), 1);
      chk("t2 ovf pre", 32'(txOverflow), 0);
      chk("t2 irq thr15", 32'(txIrq), 0);
      txThreshold = 5'd16;
      #1;
      chk("t2 irq thr16", 32'(txIrq), 1);
      flagClear = 1'b1;
      pushTx(8'h90);
      flagClear = 1'b0;
      chk("t2 ovf set-wins", 32'(txOverflow), 1);
      chk("t2 txCount held", 32'(txCount), 16);
      step();
      chk("t2 ovf sticky", 32'(txOverflow), 1);
      chk("t2 no load", 32'(loadLog.size() - base), 0);
      flagClear = 1'b1;
      step();
      flagClear = 1'b0;
      chk("t2 ovf cleared", 32'(txOverflow), 0);
      coreTransmitReady = 1'b1;
      waitTxEmpty("t2 drain");
      coreTransmitReady = 1'b0;
      chk("t2 loads", 32'(loadLog.size() - base), 16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t2 order%0d", i), 32'(loadLog[base+i]), 32'(8'h80 + 8'(i)));
      txThreshold = 5'd0;

      // Test 3: single received byte, then pop, then pop on empty
      reqBase = reqPulses;
      coreSend(8'h5A, saw);
      step();
      chk("t3 sawReq", 32'(saw), 1);
      chk("t3 reqPulses", 32'(reqPulses - reqBase), 1);
      chk("t3 rxCount", 32'(rxCount), 1);
      chk("t3 rxIrq", 32'(rxIrq), 1);
      popRx("t3 rxRdData", 8'h5A);
      chk("t3 rxEmpty", 32'(rxEmpty), 1);
      popRx("t3 pop empty data", 8'h00);
      chk("t3 rxCount empty pop", 32'(rxCount), 0);
      chk("t3 no rx flag", 32'(rxOverflow), 0);

      // Test 4: fill RX with threshold 4, overflow, clear, drain
      rxThreshold = 5'd4;
      for (int i = 0; i < 16; i++) begin
         coreSend(8'h10 + 8'(i), saw);
         chk($sformatf("t4 req%0d", i), 32'(saw), 1);
         chk($sformatf("t4 irq%0d", i), 32'(rxIrq), 32'(i + 1 >= 4));
      end
      chk("t4 rxCount", 32'(rxCount), 16);
      chk("t4 ovf pre", 32'(rxOverflow), 0);
      coreSend(8'h77, saw);
      chk("t4 req ovf", 32'(saw), 1);
      chk("t4 rxOverflow", 32'(rxOverflow), 1);
      chk("t4 rxCount held", 32'(rxCount), 16);
      chk("t4 head kept", 32'(rxRdData), 32'h10);
      flagClear = 1'b1;
      step();
      flagClear = 1'b0;
      chk("t4 ovf cleared", 32'(rxOverflow), 0);
      rxThreshold = 5'd0;
      #1;
      chk("t4 thr0 irq", 32'(rxIrq), 1);
      for (int i = 0; i < 16; i++) popRx($sformatf("t4 pop%0d", i), 8'h10 + 8'(i));
      chk("t4 rxEmpty", 32'(rxEmpty), 1);
      chk("t4 thr0 irq empty", 32'(rxIrq), 0);
      rxThreshold = 5'd1;

      // Test 5 (RX): capture and external pop in the same cycle at count 2
      coreSend(8'hAA, saw);
      coreSend(8'hBB, saw);
      chk("t5rx count pre", 32'(rxCount), 2);
      coreReceiveData = 8'hCC; coreReceiveValid = 1'b1; rxRdEn = 1'b1;
      step();
      rxRdEn = 1'b0;
      chk("t5rx count same", 32'(rxCount), 2);
      chk("t5rx readReq", 32'(coreReceiveReadReq), 1);
      step();
      coreReceiveValid = 1'b0;
      step();
      chk("t5rx no double", 32'(rxCount), 2);
      popRx("t5rx head0", 8'hBB);
      popRx("t5rx head1", 8'hCC);

      // Test 6: reset while TX is settling and RX is acknowledging
      for (int i = 0; i < 17; i++) pushTx(8'hA0 + 8'(i));
      chk("t6 txOverflow", 32'(txOverflow), 1);
      coreTransmitReady = 1'b1; coreReceiveData = 8'h55; coreReceiveValid = 1'b1;
      step();
      chk("t6 loadEn", 32'(coreTransmitLoadEn), 1);
      chk("t6 txCount", 32'(txCount), 15);
      chk("t6 readReq", 32'(coreReceiveReadReq), 1);
      reset = 1'b1; coreTransmitReady = 1'b0; coreReceiveValid = 1'b0;
      step();
      chk("t6 txCount", 32'(txCount), 0);
      chk("t6 rxCount", 32'(rxCount), 0);
      chk("t6 strobes", 32'({coreTransmitLoadEn, coreReceiveReadReq}), 0);
      chk("t6 flags", 32'({txOverflow, rxOverflow}), 0);
      chk("t6 txFull", 32'(txFull), 0);
      chk("t6 rxEmpty", 32'(rxEmpty), 1);
      chk("t6 txData", 32'(coreTransmitData), 0);
      reset = 1'b0; coreTransmitReady = 1'b1;
      pushTx(8'h5E);
      chk("t6 post no load", 32'(coreTransmitLoadEn), 0);
      step();
      chk("t6 post loadEn", 32'(coreTransmitLoadEn), 1);
      chk("t6 post data", 32'(coreTransmitData), 32'h5E);
      coreTransmitReady = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
